// File: rtl/divisor_sequencial.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one shift/subtract step per cycle.
// Optional DivZero output is enabled by defining DIV_ZERO_FLAG_EN.
module divisor_sequencial #(
  parameter int N = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             St,
  input  logic [2*N-1:0]   Dividendo,
  input  logic [N-1:0]     Divisor,
  output logic [N-1:0]     Quociente,
  output logic [N-1:0]     Resto,
  output logic             Overflow,
  output logic             Done,
`ifdef DIV_ZERO_FLAG_EN
  output logic             DivZero,
`endif
  output logic             Idle
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg;
  logic [2*N:0]    acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    d_reg;
  logic [N-1:0]    quo_reg;
  logic [N-1:0]    rem_reg;
  logic            ovf_reg;
  logic            done_reg;
`ifdef DIV_ZERO_FLAG_EN
  logic            divzero_reg;
`endif

  logic [2*N:0]    acc_shift;
  logic [2*N:0]    acc_next;
  logic [N:0]      acc_trial;
  logic            start_ovf;

  // One restoring step: shift left, then subtract D from the upper part when it fits.
  always_comb begin
    acc_shift = {acc_reg[2*N-1:0], 1'b0};
    acc_trial = acc_shift[2*N:N] - {1'b0, d_reg};
    acc_next  = acc_shift;
    if (acc_shift[2*N:N] >= {1'b0, d_reg}) begin
      acc_next[2*N:N] = acc_trial;
      acc_next[0]     = 1'b1;
    end
  end

  // A quotient fits in N bits only if the dividend's upper half is below the divisor.
  assign start_ovf = (Dividendo[2*N-1:N] >= Divisor) || (Divisor == '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      d_reg       <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      ovf_reg     <= 1'b0;
      done_reg    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      divzero_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (St) begin
            acc_reg     <= {1'b0, Dividendo};
            d_reg       <= Divisor;
            ovf_reg     <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            divzero_reg <= (Divisor == '0);
`endif
            if (start_ovf) begin
              ovf_reg   <= 1'b1;
              quo_reg   <= '0;
              rem_reg   <= '0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              cnt_reg   <= CW'(N);
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            quo_reg   <= acc_next[N-1:0];
            rem_reg   <= acc_next[2*N-1:N];
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Quociente = quo_reg;
  assign Resto     = rem_reg;
  assign Overflow  = ovf_reg;
  assign Done      = done_reg;
  assign Idle      = (state_reg == IDLE);
`ifdef DIV_ZERO_FLAG_EN
  assign DivZero   = divzero_reg;
`endif

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial (N = 4): directed cases, reset abort and random ops
// against an integer division reference model.
module tb_divisor_sequencial;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       st;
  logic [7:0] dividendo;
  logic [3:0] divisor;
  logic [3:0] q;
  logic [3:0] r;
  logic       ovf;
  logic       done;
  logic       idle;
`ifdef DIV_ZERO_FLAG_EN
  logic       divzero;
`endif

  int checks   = 0;
  int failures = 0;
  logic [3:0] prev_q = '0;

  always #5 clk = ~clk;

  divisor_sequencial #(.N(N)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .St        (st),
    .Dividendo (dividendo),
    .Divisor   (divisor),
    .Quociente (q),
    .Resto     (r),
    .Overflow  (ovf),
    .Done      (done),
`ifdef DIV_ZERO_FLAG_EN
    .DivZero   (divzero),
`endif
    .Idle      (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after Done.
  task automatic run_op(input int a, input int b, input bit hold);
    int  eq, er, lat;
    bit  eo;
    eo = (b == 0) || ((a / b) > 15);
    eq = eo ? 0 : a / b;
    er = eo ? 0 : a % b;
    dividendo = 8'(a);
    divisor   = 4'(b);
    st        = 1'b1;
    chk("idle_before_start", 32'(idle), 32'd1);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    if (!hold) st = 1'b0;
    dividendo = 8'($urandom);
    divisor   = 4'($urandom);
    chk("idle_after_start", 32'(idle), 32'd0);
    if (!eo) chk("q_hold_during_run", 32'(q), 32'(prev_q));
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("done_latency", 32'(lat), eo ? 32'd1 : 32'(N + 1));
    chk("quociente", 32'(q), 32'(eq));
    chk("resto", 32'(r), 32'(er));
    chk("overflow", 32'(ovf), 32'(eo));
`ifdef DIV_ZERO_FLAG_EN
    chk("divzero", 32'(divzero), 32'(b == 0));
`endif
    $display("op %0d/%0d -> q=%0d r=%0d ovf=%0b latency=%0d (expected q=%0d r=%0d ovf=%0b)",
             a, b, q, r, ovf, lat, eq, er, eo);
    prev_q = 4'(eq);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(idle), 32'd1);
    chk("q_hold_after_done", 32'(q), 32'(eq));
  endtask

  initial begin
    int seen_done;
    rst       = 1'b1;
    st        = 1'b0;
    dividendo = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_idle", 32'(idle), 32'd1);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_r", 32'(r), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("reset_divzero", 32'(divzero), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(100, 7, 1'b0);
    run_op(225, 15, 1'b0);
    run_op(128, 7, 1'b0);
    run_op(50, 0, 1'b0);
    run_op(9, 2, 1'b0);

    // Back-to-back with St held high: Done at latency 5 plus one idle cycle gives a 6-cycle period.
    run_op(100, 7, 1'b1);
    run_op(36, 3, 1'b1);
    run_op(49, 7, 1'b1);
    st = 1'b0;
    @(negedge clk);

    // Reset landing on the second RUN step aborts the division.
    dividendo = 8'd100;
    divisor   = 4'd7;
    st        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", 32'(idle), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_r", 32'(r), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    $display("reset abort: done pulses after abort=%0d", seen_done);
    prev_q = '0;
    run_op(100, 7, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divisor_sequencial.md
# divisor_sequencial

Sequential restoring divider that is the inverse partner of the shift-add multiplier in the arithmetic unit. It divides a 2N-bit dividend by an N-bit divisor and produces an N-bit quotient and an N-bit remainder. It uses one shift/subtract step per cycle and the same St/Done/Idle handshake as the multiplier. Overflow is detected before iteration starts, which covers quotients wider than N bits and a zero divisor.

## Interface
- N, default 4: divisor, quotient and remainder width; the dividend is 2N bits.

Ports (the clock is one clock domain; reset is synchronous and active-high):
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- St  input  1  start request; sampled only in IDLE, level-sensitive.
- Dividendo  input  2N  dividend; captured on the start edge.
- Divisor  input  N  divisor; captured on the start edge.
- Quociente  output  N  registered quotient.
- Resto  output  N  registered remainder.
- Overflow  output  1  registered; set when the quotient will not fit in N bits or Divisor = 0.
- Done  output  1  high for exactly one cycle when a result is valid.
- Idle  output  1  high while in IDLE; decoded from the state.
- DivZero  output  1  present only with DIV_ZERO_FLAG_EN (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- Internal registers:
  - accumulator ACC, 2N+1 bits;
  - step counter, ceil(log2(N+1)) bits;
  - latched divisor D, N bits.
- IDLE, when St = 1:
  - load ACC = {1'b0, Dividendo} and D = Divisor;
  - clear Overflow.
  - If Dividendo[2N-1:N] >= Divisor, or Divisor = 0: set Overflow = 1, set Quociente = 0 and Resto = 0, go to DONE.
  - Otherwise: counter = N, go to RUN.
- IDLE, when St = 0: stay in IDLE.
- RUN, once per cycle:
  - ACC <= ACC << 1.
  - If the shifted ACC[2N:N] >= {1'b0, D}: subtract D from ACC[2N:N] and set ACC[0] = 1.
  - Decrement the counter.
  - On the step where the counter goes from 1 to 0: go to DONE and load Quociente = ACC'[N-1:0], Resto = ACC'[2N-1:N], where ACC' is the post-step value.
- DONE: Done = 1 for this cycle, then go to IDLE unconditionally.
- Arithmetic:
  - The compare is unsigned and N+1 bits wide.
  - Operands are unsigned.
  - No signed mode.
- Quociente, Resto and Overflow hold their values until the next start edge. Overflow is the only field rewritten at that edge.
- St is ignored in RUN and DONE. If St is still high when the block returns to IDLE, a new division starts on the next edge using the current inputs.
- Dividendo and Divisor may change freely after the start edge; they do not affect an operation in progress.

## Timing
- The start edge is edge k, with St = 1 and Idle = 1.
- Normal case:
  - Idle drops in the cycle after edge k.
  - Done is high in the cycle after edge k+N; results are valid in that same cycle.
  - Idle returns after edge k+N+1.
  - Total latency from start edge to Done is N+1 edges.
- Overflow case: Done is high in the cycle after edge k, with Overflow = 1. Idle returns after edge k+1.
- Back-to-back operation with St held high gives one start every N+2 cycles, or every 2 cycles on overflow.
- Reset:
  - Rst = 1 at any edge forces IDLE.
  - Reset values: Done = 0, Idle = 1, Quociente = 0, Resto = 0, Overflow = 0, counter = 0, ACC = 0, plus DivZero = 0 when present.
  - Reset takes priority over St and over any step in progress; a reset mid-RUN aborts the operation and produces no Done.

## Configuration
- DIV_ZERO_FLAG_EN defined:
  - adds the output DivZero;
  - DivZero is set at the start edge when Divisor = 0, together with Overflow = 1;
  - it is cleared at the next start edge and holds otherwise.
- DIV_ZERO_FLAG_EN undefined: the DivZero port and its logic are absent, and divide-by-zero is reported through Overflow only.

## Test plan
All cases use N = 4.
- 100 / 7 → Quociente = 14, Resto = 2, Overflow = 0. Done asserts exactly 5 edges after the start edge, for one cycle.
- 225 / 15 → Quociente = 15, Resto = 0, Overflow = 0. This is the largest non-overflowing case.
- 128 / 7 → the upper nibble 8 >= 7, so Overflow = 1, Quociente = 0, Resto = 0. Done asserts one edge after start.
- 50 / 0 → Overflow = 1, and DivZero = 1 when DIV_ZERO_FLAG_EN is defined. A following 9 / 2 → Quociente = 4, Resto = 1, with Overflow and DivZero cleared.
- St held high across 3 operations (100/7, 36/3, 49/7) → results 14 r2, 12 r0, 7 r0; starts are 6 cycles apart; Idle high for exactly one cycle between operations.
- Rst pulsed during the 2nd RUN step of 100/7 → no Done. The next cycle shows Idle = 1, all outputs 0 and Overflow = 0. A fresh 100/7 then completes normally.
